// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: 8-LED pattern sequencer on the system clock. A clock-enable
// tick replaces a derived slow clock. Two debounced buttons pick one of four
// step rates, and a pause switch freezes the pattern.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL_ON   | light LEDs one by one from bit 0 up to bit 7
// FILL_OFF  | clear LEDs one by one from bit 0 up to bit 7
// BLINK_ON  | all LEDs on
// BLINK_OFF | all LEDs off; return to FILL_ON after BLINK_COUNT blink pairs
module led_seq_ctrl #(
  parameter int unsigned BASE_DIV    = 6250000,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       pause,
  output logic [7:0] q,
  output logic [1:0] speed,
  output logic [1:0] phase,
  output logic       tick
);

  localparam int unsigned CNT_W = $clog2(BASE_DIV);
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned BC_W  = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  typedef enum logic [1:0] {
    FILL_ON   = 2'd0,
    FILL_OFF  = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } state_t;

  // Bit 0 is the speed-up button and bit 1 is the speed-down button.
  logic [1:0]       btn_raw;
  logic [1:0]       meta_q, sync_q;
  logic [1:0]       deb_q, deb_d;
  logic [DEB_W-1:0] dcnt_q [2];
  logic [DEB_W-1:0] dcnt_d [2];
  logic [1:0]       press;
  logic             pz_meta_q, pz_q;

  logic [1:0]       speed_q, speed_d;
  logic             speed_chg;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_m1;
  logic             tick_c;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [7:0]       led_q, led_d;

  assign btn_raw = {btn2, btn1};

  // Two-flop synchronizers for the buttons and the pause switch.
  always_ff @(posedge clk) begin
    if (!rs) begin
      meta_q    <= '0;
      sync_q    <= '0;
      pz_meta_q <= 1'b0;
      pz_q      <= 1'b0;
    end else begin
      meta_q    <= btn_raw;
      sync_q    <= meta_q;
      pz_meta_q <= pause;
      pz_q      <= pz_meta_q;
    end
  end

  // Debounce: the level must disagree for DEB_CYCLES consecutive cycles before it is accepted.
  always_comb begin
    deb_d = deb_q;
    press = '0;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync_q[i];
          press[i] = sync_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!rs) begin
      deb_q <= '0;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Saturating speed update; two presses in the same cycle cancel out.
  always_comb begin
    speed_d = speed_q;
    if (press[0] && !press[1] && (speed_q != 2'd3)) begin
      speed_d = speed_q + 2'd1;
    end else if (press[1] && !press[0] && (speed_q != 2'd0)) begin
      speed_d = speed_q - 2'd1;
    end
    speed_chg = (speed_d != speed_q);
  end

  // Tick generator. Pause freezes the count, and a real speed change restarts it.
  always_comb begin
    per_m1 = CNT_W'((BASE_DIV >> speed_q) - 1);
    tick_c = (cnt_q == per_m1) && !pz_q;
    cnt_d  = cnt_q;
    if (speed_chg) begin
      cnt_d = '0;
    end else if (!pz_q) begin
      cnt_d = tick_c ? '0 : cnt_q + 1'b1;
    end
  end

  // Pattern FSM next state; it advances only on a tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    led_d   = led_q;
    if (tick_c) begin
      unique case (state_q)
        FILL_ON: begin
          led_d[idx_q] = 1'b1;
          idx_d        = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = FILL_OFF;
        end
        FILL_OFF: begin
          led_d[idx_q] = 1'b0;
          idx_d        = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = BLINK_ON;
        end
        BLINK_ON: begin
          led_d   = 8'hFF;
          state_d = BLINK_OFF;
        end
        BLINK_OFF: begin
          led_d = 8'h00;
          if (bcnt_q == BC_W'(BLINK_COUNT - 1)) begin
            bcnt_d  = '0;
            state_d = FILL_ON;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            state_d = BLINK_ON;
          end
        end
      endcase
    end
  end

  // Speed, tick counter and pattern state registers.
  always_ff @(posedge clk) begin
    if (!rs) begin
      speed_q <= 2'd0;
      cnt_q   <= '0;
      state_q <= FILL_ON;
      idx_q   <= 3'd0;
      bcnt_q  <= '0;
      led_q   <= 8'h00;
    end else begin
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      led_q   <= led_d;
    end
  end

  assign q     = led_q;
  assign speed = speed_q;
  assign phase = state_q;
  assign tick  = tick_c;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with small parameters. The expected LED pattern is
// queued whenever the sequence restarts and is checked at every tick. A table
// of button vectors exercises the speed control, and hand-written sequences
// cover pause and reset.
module tb_led_seq_ctrl;
  localparam int BASE  = 16;
  localparam int DEB   = 4;
  localparam int BLINK = 2;
  localparam int PLEN  = 16 + 2 * BLINK;

  logic       clk = 1'b0;
  logic       rs = 1'b0, btn1 = 1'b0, btn2 = 1'b0, pause = 1'b0;
  logic [7:0] q;
  logic [1:0] speed, phase;
  logic       tick;

  led_seq_ctrl #(.BASE_DIV(BASE), .DEB_CYCLES(DEB), .BLINK_COUNT(BLINK)) dut (
    .clk(clk), .rs(rs), .btn1(btn1), .btn2(btn2), .pause(pause),
    .q(q), .speed(speed), .phase(phase), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] eq; logic [1:0] eph; } exp_t;
  typedef struct { int b1; int b2; int spd; } vec_t;

  exp_t sb[$];
  int   n_pass = 0, n_chk = 0;
  int   cyc = 0, tick_n = 0, last_tick = 0, prev_tick = 0, rel0 = 0;
  bit   chk_pend = 0;

  task automatic check(string name, int act, int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // LED value and phase expected right after the k-th tick of a fresh pattern.
  function automatic exp_t pat(int k);
    int   m;
    exp_t e;
    m = (k - 1) % PLEN;
    if (m < 8) begin
      e.eq  = 8'((1 << (m + 1)) - 1);
      e.eph = (m == 7) ? 2'd1 : 2'd0;
    end else if (m < 16) begin
      e.eq  = 8'((255 << (m - 7)) & 255);
      e.eph = (m == 15) ? 2'd2 : 2'd1;
    end else if (((m - 16) % 2) == 0) begin
      e.eq  = 8'hFF;
      e.eph = 2'd3;
    end else begin
      e.eq  = 8'h00;
      e.eph = (m == PLEN - 1) ? 2'd0 : 2'd2;
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Count ticks, remember the edges they land on, and check q/phase after each one.
  always @(negedge clk) begin
    exp_t e;
    if (!rs) begin
      chk_pend = 0;
    end else if (chk_pend) begin
      chk_pend = 0;
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check("tick_q", int'(q), int'(e.eq));
        check("tick_phase", int'(phase), int'(e.eph));
      end
    end
    if (tick === 1'b1) begin
      tick_n++;
      prev_tick = last_tick;
      last_tick = cyc + 1;
      chk_pend  = 1;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Returns just after the edge of the target tick has taken effect.
  task automatic wait_ticks(int target, int budget, string name);
    int b;
    b = 0;
    while (tick_n < target && b < budget) begin
      step();
      b++;
    end
    if (tick_n < target) check({name, "_timeout"}, tick_n, target);
    step();
  endtask

  task automatic do_reset(int ncyc);
    rs = 1'b0;
    step(ncyc);
    check("rst_q", int'(q), 0);
    check("rst_speed", int'(speed), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_tick", int'(tick), 0);
    sb.delete();
    for (int k = 1; k <= 400; k++) sb.push_back(pat(k));
    tick_n = 0;
    rs     = 1'b1;
    rel0   = cyc + 1;
  endtask

  task automatic first_ticks();
    wait_ticks(1, 100, "first_tick");
    check("first_tick_cycle", last_tick - rel0, 15);
    wait_ticks(2, 100, "second_tick");
    check("second_tick_cycle", last_tick - rel0, 31);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    int   exp_speed, y, b;

    vt[0]  = '{10, 0, 1};  vt[1]  = '{10, 0, 2};  vt[2]  = '{10, 0, 3};
    vt[3]  = '{10, 0, 3};  vt[4]  = '{0, 10, 2};  vt[5]  = '{0, 10, 1};
    vt[6]  = '{0, 10, 0};  vt[7]  = '{0, 10, 0};  vt[8]  = '{2, 0, 0};
    vt[9]  = '{10, 10, 0}; vt[10] = '{10, 0, 1};  vt[11] = '{10, 10, 1};
    vt[12] = '{0, 3, 1};   vt[13] = '{0, 4, 0};

    // Power-up reset, first two ticks, then one complete pattern cycle.
    do_reset(3);
    first_ticks();
    wait_ticks(PLEN + 1, (PLEN + 2) * BASE, "full_cycle");
    check("full_cycle_q", int'(q), 1);

    // Speed table: press, let it settle, then check level, grid alignment and tick spacing.
    exp_speed = 0;
    for (int i = 0; i < 14; i++) begin
      int t_ref, p_exp;
      t_ref = last_tick;
      btn1  = (vt[i].b1 > 0);
      btn2  = (vt[i].b2 > 0);
      for (int c = 0; c < 10; c++) begin
        if (c == vt[i].b1) btn1 = 1'b0;
        if (c == vt[i].b2) btn2 = 1'b0;
        step();
      end
      btn1 = 1'b0;
      btn2 = 1'b0;
      step(12);
      check("speed", int'(speed), vt[i].spd);
      p_exp = BASE >> vt[i].spd;
      if (vt[i].spd == exp_speed) begin
        wait_ticks(tick_n + 1, 100, "grid");
        check("grid_no_clear", (last_tick - t_ref) % p_exp, 0);
      end
      wait_ticks(tick_n + 2, 100, "spacing");
      check("tick_spacing", last_tick - prev_tick, p_exp);
      exp_speed = vt[i].spd;
    end

    // Reset from an arbitrary state, then pause after the third tick.
    do_reset(3);
    first_ticks();
    wait_ticks(3, 100, "pause_pre");
    check("pre_pause_q", int'(q), 8'h07);
    pause = 1'b1;
    step(100);
    check("pause_ticks", tick_n, 3);
    check("pause_q", int'(q), 8'h07);
    check("pause_phase", int'(phase), 0);
    pause = 1'b0;
    y = cyc;
    wait_ticks(4, 100, "resume");
    check("resume_cycle", last_tick - y, 16);
    check("resume_q", int'(q), 8'h0F);

    // A speed-up press while paused clears the count, so the first tick comes a full new period after release.
    pause = 1'b1;
    step(5);
    btn1 = 1'b1;
    step(10);
    btn1 = 1'b0;
    step(12);
    check("pause_press_speed", int'(speed), 1);
    check("pause_press_ticks", tick_n, 4);
    pause = 1'b0;
    y = cyc;
    wait_ticks(5, 100, "resume2");
    check("resume2_cycle", last_tick - y, 10);

    // One-cycle reset while in BLINK_ON.
    b = 0;
    while (phase != 2'd2 && b < 2000) begin
      step();
      b++;
    end
    check("reach_blink", int'(phase), 2);
    do_reset(1);
    first_ticks();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Single-clock controller for the 8-LED pattern path. Replaces the derived slow clock with a clock-enable tick generator running on the 50 MHz system clock.
- Debounces the two speed buttons to select one of four step rates and honours the pause switch.
- Sequences the pattern FSM: fill on, fill off, blink all N times, repeat.
- Sits directly under top_level and drives q[7:0].

Parameters:
- BASE_DIV, 6250000, step period in clk cycles at speed 0 (8 Hz at 50 MHz). Must be ≥ 8 and a multiple of 8.
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (20 ms).
- BLINK_COUNT, 3, number of all-on/all-off blink pairs per pattern cycle. Must be ≥ 1.

Ports:
- clk  in  1  system clock, 50 MHz; all logic on the rising edge.
- rs  in  1  reset, synchronous, active-low.
- btn1  in  1  raw speed-up button, active-high, asynchronous.
- btn2  in  1  raw speed-down button, active-high, asynchronous.
- pause  in  1  level switch, active-high, asynchronous; freezes the pattern.
- q  out  8  LED outputs.
- speed  out  2  current speed level, 0 (slowest) to 3.
- phase  out  2  FSM state: 0 FILL_ON, 1 FILL_OFF, 2 BLINK_ON, 3 BLINK_OFF.
- tick  out  1  one-cycle step strobe (debug/observation).

Behaviour:
- Reset: on a clk edge with rs=0, all state clears.
  - q=8'h00, speed=0, phase=FILL_ON, tick=0.
  - Step index, blink counter, tick counter and debounce counters all 0.
  - Debounced button levels = 0; synchronizers = 0.
  - Reset asserted mid-operation takes effect on that same edge.
- Input synchronization: btn1, btn2 and pause each pass through a 2-FF synchronizer.
- Debounce, per button:
  - A counter increments on every cycle where the synchronized level differs from the debounced level. Any cycle where they match clears the counter.
  - When the counter reaches DEB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - A 0→1 transition of the debounced level produces a one-cycle press pulse.
  - Glitches shorter than DEB_CYCLES cycles have no effect.
- Speed control:
  - btn1 press alone: speed+1, saturating at 3.
  - btn2 press alone: speed-1, saturating at 0.
  - Both presses in the same cycle: no change.
  - Buttons act even while paused.
  - Any actual change of speed clears the tick counter in that cycle.
- Tick generator:
  - Period P = BASE_DIV >> speed.
  - The counter runs 0..P-1. tick=1 for the one cycle where counter==P-1 and pause is low; the counter then wraps to 0.
  - While synchronized pause=1: the counter holds its value, tick=0, FSM and q hold.
  - On pause release, counting resumes from the held value.
- FSM: advances only on tick=1, using step index idx (0..7) and blink counter bcnt.
  - FILL_ON: q[idx]←1. If idx==7, go to FILL_OFF with idx←0; otherwise idx+1.
  - FILL_OFF: q[idx]←0. If idx==7, go to BLINK_ON with idx←0; otherwise idx+1.
  - BLINK_ON: q←8'hFF, go to BLINK_OFF.
  - BLINK_OFF: q←8'h00. If bcnt==BLINK_COUNT-1, go to FILL_ON with bcnt←0; otherwise bcnt+1 and go to BLINK_ON.
  - One pattern cycle = 16 + 2·BLINK_COUNT ticks.
- Timing and registration:
  - q, phase and speed are registered and update on the same edge where tick is high.
  - q changes only on tick edges or reset.

Test Plan (BASE_DIV=16, DEB_CYCLES=4, BLINK_COUNT=2; cycle 0 = first edge with rs=1):
- Reset: rs=0 for 3 cycles from arbitrary state → q=00, speed=0, phase=0. First tick at cycle 15, q=01 after it; second tick at cycle 31, q=03.
- Full sequence at speed 0:
  - Tick 8 → q=FF, phase=1.
  - Tick 16 → q=00, phase=2.
  - Ticks 17/18/19/20 → FF/00/FF/00.
  - Tick 21 → q=01, phase=0.
- Speed and debounce:
  - btn1 high for 10 cycles → speed=1, tick spacing 8 cycles.
  - Three further presses → speed=3 (spacing 2); a fourth press keeps speed=3.
  - Four btn2 presses → speed=0.
  - A 2-cycle btn1 glitch → no change.
- Simultaneous buttons: btn1 and btn2 raised on the same cycle and held 10 cycles → speed unchanged, no tick-counter clear.
- Pause:
  - After tick 3 (q=07), pause=1 for 100 cycles → q stays 07, tick never asserts, phase stays 0.
  - Release → next tick occurs (P - held count) cycles after the synchronized release; q=0F.
  - btn1 press during pause → speed=1, and the first tick after release arrives 8 cycles after release sync.
- Reset mid-blink: rs=0 for one cycle while phase=2 → next edge shows q=00, phase=0, speed=0; sequence restarts as in the reset scenario.
